key_event_decoder: RTL and testbench

- Input-side counterpart of the watch's seven-segment display path: converts raw active-low KEY buttons into clean, per-key, single-cycle event pulses.
- Per key: synchroniser, debouncer, press/release/short/long/auto-repeat event generator.
- Sits between the board KEY pins and the mode/clock/stopwatch/countdown logic, and replaces ad-hoc edge and press-hold handling.

---
 rtl/key_event_if.sv | 23 ++
 rtl/key_event_decoder.sv | 158 +++++++++++++++
 tb/tb_key_event_decoder.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/key_event_if.sv
// Key channel bundle: raw active-low KEY pins in, debounced level and event pulses out.
interface key_event_if #(
  parameter int unsigned NKEYS = 4
) ();
  logic [NKEYS-1:0] key_n;
  logic [NKEYS-1:0] pressed;
  logic [NKEYS-1:0] press;
  logic [NKEYS-1:0] release_evt;
  logic [NKEYS-1:0] short_press;
  logic [NKEYS-1:0] long_press;
  logic [NKEYS-1:0] repeat_evt;

  // The decoder side: samples the pins, drives the events.
  modport master (
    input  key_n,
    output pressed, press, release_evt, short_press, long_press, repeat_evt
  );

  modport slave (
    output key_n,
    input  pressed, press, release_evt, short_press, long_press, repeat_evt
  );
endinterface

// File: rtl/key_event_decoder.sv
// Per-key synchroniser, debouncer and press/release/short/long/auto-repeat event generator.
// Channels are fully independent; every event is a registered single-cycle pulse.
module key_event_decoder #(
  parameter int unsigned NKEYS    = 4,
  parameter int unsigned DEB_CYC  = 1000000,
  parameter int unsigned LONG_CYC = 50000000,
  parameter int unsigned REP_CYC  = 5000000
) (
  input  logic        clk,
  input  logic        reset_n,
  key_event_if.master ev
);

  localparam int unsigned DebW  = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int unsigned LongW = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1;
  localparam int unsigned RepW  = (REP_CYC > 1) ? $clog2(REP_CYC) : 1;

  localparam logic [DebW-1:0]  DebMax  = DebW'(DEB_CYC - 1);
  localparam logic [LongW-1:0] LongMax = LongW'(LONG_CYC - 1);
  localparam logic [RepW-1:0]  RepMax  = RepW'(REP_CYC - 1);

  typedef enum logic [1:0] {StIdle, StHeld, StLong} state_e;

  logic [NKEYS-1:0] pressed_w;
  logic [NKEYS-1:0] press_w;
  logic [NKEYS-1:0] release_w;
  logic [NKEYS-1:0] short_w;
  logic [NKEYS-1:0] long_w;
  logic [NKEYS-1:0] repeat_w;

  for (genvar k = 0; k < NKEYS; k++) begin : g_key
    logic [1:0]       sync_q;
    logic             sync_lvl;
    logic             stable_q, stable_d;
    logic             rise, fall;
    logic [DebW-1:0]  deb_cnt_q, deb_cnt_d;
    logic [LongW-1:0] hold_cnt_q, hold_cnt_d;
    logic [RepW-1:0]  rep_cnt_q, rep_cnt_d;
    state_e           state_q, state_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;

    // Synchroniser holds the raw pin level, so its reset value of 1 means released.
    assign sync_lvl = ~sync_q[1];

    always_comb begin
      stable_d  = stable_q;
      deb_cnt_d = '0;
      if (sync_lvl != stable_q) begin
        if (deb_cnt_q == DebMax) begin
          stable_d = sync_lvl;
        end else begin
          deb_cnt_d = deb_cnt_q + DebW'(1);
        end
      end
    end

    // Events key off the debounced edge being committed this cycle, not the old level.
    assign rise = ~stable_q & stable_d;
    assign fall = stable_q & ~stable_d;

    always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      rep_cnt_d  = rep_cnt_q;
      press_d    = 1'b0;
      release_d  = 1'b0;
      short_d    = 1'b0;
      long_d     = 1'b0;
      repeat_d   = 1'b0;
      unique case (state_q)
        StIdle: begin
          hold_cnt_d = '0;
          rep_cnt_d  = '0;
          if (rise) begin
            press_d = 1'b1;
            state_d = StHeld;
          end
        end
        StHeld: begin
          if (fall) begin
            release_d  = 1'b1;
            short_d    = 1'b1;
            hold_cnt_d = '0;
            state_d    = StIdle;
          end else if (hold_cnt_q == LongMax) begin
            long_d     = 1'b1;
            repeat_d   = 1'b1;
            hold_cnt_d = '0;
            rep_cnt_d  = '0;
            state_d    = StLong;
          end else begin
            hold_cnt_d = hold_cnt_q + LongW'(1);
          end
        end
        StLong: begin
          if (fall) begin
            release_d = 1'b1;
            rep_cnt_d = '0;
            state_d   = StIdle;
          end else if (rep_cnt_q == RepMax) begin
            repeat_d  = 1'b1;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + RepW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync_q     <= 2'b11;
        stable_q   <= 1'b0;
        deb_cnt_q  <= '0;
        hold_cnt_q <= '0;
        rep_cnt_q  <= '0;
        state_q    <= StIdle;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
        short_q    <= 1'b0;
        long_q     <= 1'b0;
        repeat_q   <= 1'b0;
      end else begin
        sync_q     <= {sync_q[0], ev.key_n[k]};
        stable_q   <= stable_d;
        deb_cnt_q  <= deb_cnt_d;
        hold_cnt_q <= hold_cnt_d;
        rep_cnt_q  <= rep_cnt_d;
        state_q    <= state_d;
        press_q    <= press_d;
        release_q  <= release_d;
        short_q    <= short_d;
        long_q     <= long_d;
        repeat_q   <= repeat_d;
      end
    end

    assign pressed_w[k] = stable_q;
    assign press_w[k]   = press_q;
    assign release_w[k] = release_q;
    assign short_w[k]   = short_q;
    assign long_w[k]    = long_q;
    assign repeat_w[k]  = repeat_q;
  end

  assign ev.pressed     = pressed_w;
  assign ev.press       = press_w;
  assign ev.release_evt = release_w;
  assign ev.short_press = short_w;
  assign ev.long_press  = long_w;
  assign ev.repeat_evt  = repeat_w;

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench for key_event_decoder: stimulus queues timed event records, a negedge
// monitor matches every output pulse against them.
module tb_key_event_decoder;

  localparam int NK   = 4;
  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int REP  = 5;

  typedef struct {
    int       cyc;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] sht;
    logic [3:0] lng;
    logic [3:0] rpt;
  } exp_t;

  logic clk;
  logic reset_n;
  int   cyc;
  int   n_chk;
  int   n_fail;
  bit   mon_en;
  exp_t q[$];

  key_event_if #(.NKEYS(NK)) ev ();

  key_event_decoder #(
    .NKEYS   (NK),
    .DEB_CYC (DEB),
    .LONG_CYC(LONG),
    .REP_CYC (REP)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .ev     (ev)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc%0d: got %0h, required %0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_zero(input string name);
    chk(name, {8'h0, ev.pressed, ev.press, ev.release_evt, ev.short_press, ev.long_press,
               ev.repeat_evt}, 32'h0);
  endtask

  // kind: 0 press, 1 release, 2 short, 3 long, 4 repeat
  function automatic void exp_add(input int c, input int k, input int kind);
    int   i;
    exp_t e;
    for (i = 0; i < q.size(); i++) begin
      if (q[i].cyc >= c) break;
    end
    if (!(i < q.size() && q[i].cyc == c)) begin
      e.cyc = c; e.prs = '0; e.rel = '0; e.sht = '0; e.lng = '0; e.rpt = '0;
      q.insert(i, e);
    end
    e = q[i];
    case (kind)
      0: e.prs[k] = 1'b1;
      1: e.rel[k] = 1'b1;
      2: e.sht[k] = 1'b1;
      3: e.lng[k] = 1'b1;
      default: e.rpt[k] = 1'b1;
    endcase
    q[i] = e;
  endfunction

  // Key k held low for len cycles starting now; queue the events that hold must produce.
  task automatic hold_key(input int k, input int len);
    int n;
    int le;
    int re;
    n  = cyc;
    le = n + 6 + LONG;
    re = n + len + 6;
    exp_add(n + 6, k, 0);
    exp_add(re, k, 1);
    if (re <= le) begin
      exp_add(re, k, 2);
    end else begin
      exp_add(le, k, 3);
      for (int t = le; t < re; t += REP) exp_add(t, k, 4);
    end
    ev.key_n[k] = 1'b0;
    repeat (6) @(negedge clk);
    chk($sformatf("pressed_on_k%0d", k), 32'(ev.pressed[k]), 32'd1);
    repeat (len - 6) @(negedge clk);
    ev.key_n[k] = 1'b1;
    repeat (6) @(negedge clk);
    chk($sformatf("pressed_off_k%0d", k), 32'(ev.pressed[k]), 32'd0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL missed_event @cyc%0d: got nothing, required prs=%b rel=%b sht=%b lng=%b rpt=%b",
                 q[0].cyc, q[0].prs, q[0].rel, q[0].sht, q[0].lng, q[0].rpt);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        n_chk++;
        if ({ev.press, ev.release_evt, ev.short_press, ev.long_press, ev.repeat_evt} !==
            {q[0].prs, q[0].rel, q[0].sht, q[0].lng, q[0].rpt}) begin
          n_fail++;
          $display("FAIL event @cyc%0d: got prs=%b rel=%b sht=%b lng=%b rpt=%b, required prs=%b rel=%b sht=%b lng=%b rpt=%b",
                   cyc, ev.press, ev.release_evt, ev.short_press, ev.long_press, ev.repeat_evt,
                   q[0].prs, q[0].rel, q[0].sht, q[0].lng, q[0].rpt);
        end
        void'(q.pop_front());
      end else if ({ev.press, ev.release_evt, ev.short_press, ev.long_press, ev.repeat_evt}
                   != '0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_event @cyc%0d: got prs=%b rel=%b sht=%b lng=%b rpt=%b, required none",
                 cyc, ev.press, ev.release_evt, ev.short_press, ev.long_press, ev.repeat_evt);
      end
    end
  end

  initial begin
    int n;
    n_chk    = 0;
    n_fail   = 0;
    mon_en   = 1'b0;
    reset_n  = 1'b0;
    ev.key_n = 4'b0000;
    #2;
    check_zero("reset_async_no_clock");

    // All keys held through reset: fresh press on every channel after release.
    repeat (3) @(negedge clk);
    mon_en  = 1'b1;
    reset_n = 1'b1;
    n = cyc;
    for (int k = 0; k < NK; k++) begin
      exp_add(n + 6, k, 0);
      exp_add(n + 16, k, 1);
      exp_add(n + 16, k, 2);
    end
    repeat (5) @(negedge clk);
    chk("pressed_before_deb", 32'(ev.pressed), 32'h0);
    @(negedge clk);
    chk("pressed_after_reset", 32'(ev.pressed), 32'hf);
    repeat (4) @(negedge clk);
    ev.key_n = 4'b1111;
    repeat (6) @(negedge clk);
    chk("pressed_all_released", 32'(ev.pressed), 32'h0);
    repeat (3) @(negedge clk);

    // Glitch shorter than the debounce window.
    ev.key_n[0] = 1'b0;
    repeat (3) @(negedge clk);
    ev.key_n[0] = 1'b1;
    repeat (10) @(negedge clk);
    chk("glitch_pressed", 32'(ev.pressed), 32'h0);

    hold_key(1, 10);
    repeat (3) @(negedge clk);
    hold_key(2, 40);
    repeat (3) @(negedge clk);
    // Release lands on the long threshold edge: release wins, counts as short.
    hold_key(1, 20);
    repeat (3) @(negedge clk);

    fork
      hold_key(3, 40);
      begin
        repeat (7) @(negedge clk);
        hold_key(0, 8);
      end
    join
    repeat (3) @(negedge clk);

    // Reset while key 2 sits in the long-hold state.
    n = cyc;
    exp_add(n + 6, 2, 0);
    exp_add(n + 26, 2, 3);
    exp_add(n + 26, 2, 4);
    ev.key_n[2] = 1'b0;
    repeat (29) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_zero("reset_mid_hold");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    hold_key(2, 33);

    repeat (10) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
